// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - instruction memory request/ack bus between fetch stage and memory
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID register, stall hold buffer and redirect squash
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    if_stage_if.master  imem,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pending_pc, pending_nxt;
    logic [31:0] hold_instr, hold_instr_nxt;
    logic [31:0] hold_pc, hold_pc_nxt;
    logic [31:0] instr_nxt, pc_out_nxt;
    logic        valid_nxt;
    logic [31:0] target;
    logic [31:0] pc_inc;

    assign target = redirect_pc & ~32'h3;
    assign pc_inc = pc + 32'd4;

    assign imem.imem_req  = !reset && (state != HOLD);
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            pending_pc <= RESET_PC;
            hold_instr <= 32'h0;
            hold_pc    <= 32'h0;
            instr_out  <= NOP_INSTR;
            pc_out     <= 32'h0;
            valid_out  <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pending_pc <= pending_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc    <= hold_pc_nxt;
            instr_out  <= instr_nxt;
            pc_out     <= pc_out_nxt;
            valid_out  <= valid_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        pending_nxt    = pending_pc;
        hold_instr_nxt = hold_instr;
        hold_pc_nxt    = hold_pc;
        instr_nxt      = instr_out;
        pc_out_nxt     = pc_out;
        valid_nxt      = valid_out;

        case (state)
            FETCH: begin
                if (redirect_valid) begin
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                    if (imem.imem_ack) begin
                        pc_nxt = target;
                    end else begin
                        // outstanding request must complete before the new target is issued
                        pending_nxt = target;
                        state_nxt   = SQUASH;
                    end
                end else if (imem.imem_ack) begin
                    pc_nxt = pc_inc;
                    if (stall) begin
                        hold_instr_nxt = imem.imem_rdata;
                        hold_pc_nxt    = pc;
                        state_nxt      = HOLD;
                    end else begin
                        instr_nxt  = imem.imem_rdata;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                    end
                end else if (!stall) begin
                    valid_nxt = 1'b0;
                    instr_nxt = NOP_INSTR;
                end
            end
            SQUASH: begin
                valid_nxt = 1'b0;
                instr_nxt = NOP_INSTR;
                if (redirect_valid) begin
                    pending_nxt = target;
                end
                if (imem.imem_ack) begin
                    pc_nxt    = redirect_valid ? target : pending_pc;
                    state_nxt = FETCH;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    valid_nxt      = 1'b0;
                    instr_nxt      = NOP_INSTR;
                    pc_nxt         = target;
                    hold_instr_nxt = 32'h0;
                    hold_pc_nxt    = 32'h0;
                    state_nxt      = FETCH;
                end else if (!stall) begin
                    instr_nxt  = hold_instr;
                    pc_out_nxt = hold_pc;
                    valid_nxt  = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

endmodule
